// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - round-robin reconfiguration scheduler for a bank of variable-decimation CIC filters (optional flush watchdog: CIC_CTRL_TIMEOUT_EN)
module cic_decim_ctrl #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int MD         = 18,
    parameter int MAX_LOG2   = 14,
    parameter int STAGES     = 5,
    parameter int TMO_CYCLES = 65535
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cfg_wr,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [3:0]          cfg_log2,
    output logic                cfg_err,
    output logic [NCH-1:0]      pending,
    output logic                busy,
    output logic [NCH*MD-1:0]   decim,
    output logic [NCH-1:0]      cic_rst,
    input  logic [NCH-1:0]      cic_strobe,
    output logic [NCH-1:0]      gate,
    output logic                done,
    output logic [CHW-1:0]      done_ch,
    output logic                tmo
);

`ifdef CIC_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int CW = $clog2(STAGES + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_RST1, S_RST2, S_FLUSH, S_DONE
    } state_t;

    state_t         state;
    logic [CHW-1:0] rr;
    logic [CHW-1:0] cur_ch;
    logic [3:0]     cur_exp;
    logic [3:0]     shadow [NCH];
    logic [CW-1:0]  fcnt;
    logic [15:0]    tcnt;
    logic           tmo_hit;
    logic           tmo_q;

    logic           req_v;
    logic           req_bad;
    logic [CHW-1:0] req_ch;
    logic [3:0]     req_log2;

    logic [31:0]    ch_ext;
    logic           bad_now;
    logic [CHW-1:0] grant_ch;

    assign ch_ext  = 32'(cfg_ch);
    assign bad_now = (cfg_log2 > 4'(MAX_LOG2)) || (ch_ext >= 32'(NCH));
    assign busy    = (state != S_IDLE);
    assign tmo     = TMO_EN ? tmo_q : 1'b0;

    // Register incoming requests so host timing never reaches the scheduler combinationally
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_v    <= 1'b0;
            req_bad  <= 1'b0;
            req_ch   <= '0;
            req_log2 <= '0;
        end else begin
            req_v    <= cfg_wr;
            req_bad  <= bad_now;
            req_ch   <= cfg_ch;
            req_log2 <= cfg_log2;
        end
    end

    // Pick the first pending channel strictly after the round-robin pointer
    always_comb begin
        int idx;
        idx      = 0;
        grant_ch = rr;
        for (int i = NCH; i >= 1; i--) begin
            idx = (int'(rr) + i) % NCH;
            if (pending[CHW'(idx)]) grant_ch = CHW'(idx);
        end
    end

    // Service FSM; request capture is applied last so a same-cycle write keeps pending set
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pending <= '0;
            decim   <= {NCH{MD'(1)}};
            cic_rst <= '1;
            gate    <= '0;
            cfg_err <= 1'b0;
            done    <= 1'b0;
            done_ch <= '0;
            tmo_q   <= 1'b0;
            rr      <= CHW'(NCH - 1);
            cur_ch  <= '0;
            cur_exp <= '0;
            fcnt    <= '0;
            tcnt    <= '0;
            tmo_hit <= 1'b0;
            for (int k = 0; k < NCH; k++) shadow[k] <= '0;
        end else begin
            done    <= 1'b0;
            tmo_q   <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|pending) begin
                        state            <= S_GRANT;
                        cur_ch           <= grant_ch;
                        cur_exp          <= shadow[grant_ch];
                        pending[grant_ch] <= 1'b0;
                        gate[grant_ch]   <= 1'b0;
                        rr               <= grant_ch;
                    end
                end
                S_GRANT: begin
                    state                  <= S_RST1;
                    cic_rst[cur_ch]        <= 1'b1;
                    decim[cur_ch*MD +: MD] <= MD'(1) << cur_exp;
                end
                S_RST1: begin
                    state <= S_RST2;
                end
                S_RST2: begin
                    state           <= S_FLUSH;
                    cic_rst[cur_ch] <= 1'b0;
                    fcnt            <= '0;
                    tcnt            <= '0;
                    tmo_hit         <= 1'b0;
                end
                S_FLUSH: begin
                    tcnt <= tcnt + 16'd1;
                    if (cic_strobe[cur_ch] && fcnt == CW'(STAGES)) begin
                        state <= S_DONE;
                    end else if (TMO_EN && tcnt == 16'(TMO_CYCLES - 1)) begin
                        state   <= S_DONE;
                        tmo_hit <= 1'b1;
                    end else if (cic_strobe[cur_ch]) begin
                        fcnt <= fcnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    gate[cur_ch] <= 1'b1;
                    done         <= 1'b1;
                    done_ch      <= cur_ch;
                    tmo_q        <= tmo_hit;
                end
                default: state <= S_IDLE;
            endcase
            if (req_v) begin
                if (req_bad) begin
                    cfg_err <= 1'b1;
                end else begin
                    shadow[req_ch]  <= req_log2;
                    pending[req_ch] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/cic_decim_ctrl.md
# cic_decim_ctrl

Reconfiguration scheduler for a bank of variable-decimation CIC decimators (`cic_prune_var` instances built with DECIMATION<0). It accepts decimation-change requests from the host register interface and services one channel at a time in round-robin order. For the channel being serviced it:
- drives the new power-of-two decimation value;
- resets the CIC;
- discards the transient output samples;
- then re-opens that channel's output gate to the downstream FIFO.

## Interface
Parameters:
- NCH, 4, number of CIC channels served
- CHW, 2, channel index width, clog2(NCH)
- MD, 18, decimation word width (matches CIC `decimation` port)
- MAX_LOG2, 14, largest legal exponent (R = 2**MAX_LOG2 = 16384)
- STAGES, 5, CIC stage count; flush length is STAGES+1 output strobes
- TMO_CYCLES, 65535, flush watchdog limit in clocks (only used with CIC_CTRL_TIMEOUT_EN)

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- cfg_wr  in  1  one-cycle request strobe
- cfg_ch  in  CHW  target channel of request
- cfg_log2  in  4  requested exponent, R = 2**cfg_log2
- cfg_err  out  1  one-cycle pulse: request rejected (cfg_log2 > MAX_LOG2 or cfg_ch >= NCH)
- pending  out  NCH  per-channel request-outstanding flags
- busy  out  1  1 whenever state != IDLE
- decim  out  NCH*MD  channel k decimation at [k*MD +: MD], equal to 1 << exponent
- cic_rst  out  NCH  synchronous reset into each CIC
- cic_strobe  in  NCH  out_strobe from each CIC
- gate  out  NCH  1 = channel output forwarded downstream
- done  out  1  one-cycle pulse: reconfiguration of done_ch complete
- done_ch  out  CHW  channel of the last completion
- tmo  out  1  one-cycle pulse with done when the flush watchdog fired

## Operation
Reset values (reset_n low, asynchronous):
- state=IDLE, pending=0, every decim field=1, cic_rst all 1, gate all 0, shadow exponents=0.
- cfg_err=0, done=0, done_ch=0, tmo=0, rr pointer=NCH-1.
- After reset release, each channel still needs one request before its gate opens.

Request capture:
- A valid cfg_wr writes shadow[cfg_ch]=cfg_log2 and sets pending[cfg_ch].
- An invalid cfg_wr pulses cfg_err on the next cycle. Shadow and pending are unchanged.
- A write to an already-pending channel overwrites its shadow; the last write wins.

Arbitration:
- In IDLE with any pending bit set, grant the first pending channel strictly after the rr pointer, wrapping modulo NCH.
- rr pointer := granted channel.

FSM:
- IDLE -> GRANT when pending != 0.
- GRANT (1 cycle): latch ch and exp=shadow[ch], clear pending[ch], gate[ch]:=0.
- RST (2 cycles): cic_rst[ch]=1; decim[ch] := 1<<exp on the first RST cycle.
- FLUSH: cic_rst[ch]=0; count cic_strobe[ch] pulses.
- FLUSH -> DONE on the (STAGES+1)th pulse.
- DONE (1 cycle): gate[ch]:=1, done=1, done_ch=ch.
- DONE -> IDLE.

Rules while a channel is being serviced:
- Other channels' decim, cic_rst and gate are untouched.
- A cfg_wr to the in-service channel sets pending again and is serviced in a later round. The current service keeps the exponent latched at GRANT.
- If cfg_wr hits channel X in the same cycle that GRANT latches X, the latch takes the old shadow and pending[X] stays set.

Exponent 0 (R=1) follows the same flush sequence.

## Timing
With the write sampled at edge N and the block idle:
- After edge N+1: pending=1. After edge N+2: GRANT.
- After edges N+3 and N+4: cic_rst high. decim is valid after edge N+3.
- After edge N+5: FLUSH.
- If the final counted strobe is sampled at edge M, then after edge M+1: done=1 and gate=1.
- done and gate are registered; there is no combinational path from inputs to outputs.
- Back-to-back channels: IDLE occupies 1 cycle between DONE and the next GRANT.

## Configuration
- CIC_CTRL_TIMEOUT_EN defined:
  - A 16-bit cycle counter runs in FLUSH.
  - When it reaches TMO_CYCLES, the FSM goes to DONE, and done and tmo pulse together.
  - The gate still opens.
- CIC_CTRL_TIMEOUT_EN undefined:
  - FLUSH waits indefinitely and tmo is tied 0.
  - The port list is identical in both builds.

## Test plan
- Reset, then cfg_wr ch1, log2=9, with ch1 strobes every 8 clocks -> decim[1]=512; cic_rst[1] high exactly 2 cycles; done after the 6th strobe with done_ch=1; gate[1]=1; other fields still 1.
- cfg_log2=15 -> cfg_err pulse 1 cycle; pending=0; no FSM activity.
- Writes to ch3, ch0, ch2 in the same idle window, rr=3 -> service order 0, 2, 3; exactly 3 done pulses.
- Write ch2 log2=4, then during FLUSH write ch2 log2=6 -> first done gives decim[2]=16; second service gives 64.
- Assert reset_n low mid-FLUSH -> all outputs return to reset values immediately; pending cleared.
- With CIC_CTRL_TIMEOUT_EN and TMO_CYCLES=100, no strobes -> done and tmo pulse 100 cycles after FLUSH entry; gate opens. Without the macro, no done after 10000 cycles.
